// File: rtl/xmit_arb_ctrl_if.sv
// xmit_arb_ctrl_if: requester and UART-transmitter signals shared with the arbiter
interface xmit_arb_ctrl_if;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [3:0]  done;
  logic        err;
  logic        busy;
  logic [1:0]  grant_id;
  logic        xmit_o;
  logic [7:0]  xmit_data_o;
  logic        xmit_done_i;
  modport master (
    output req, req_data, xmit_done_i,
    input  ack, done, err, busy, grant_id, xmit_o, xmit_data_o
  );
  modport slave (
    input  req, req_data, xmit_done_i,
    output ack, done, err, busy, grant_id, xmit_o, xmit_data_o
  );
endinterface

// File: rtl/xmit_arb_ctrl.sv
// xmit_arb_ctrl: 4-way round-robin arbiter for one UART transmitter; XMIT_ARB_PRIO0_EN gives requester 0 fixed priority
module xmit_arb_ctrl #(
  parameter int TMO_CYC = 7
) (
  input logic            sys_clk,
  input logic            sys_rst_l,
  xmit_arb_ctrl_if.slave io
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
  state_t     state, stateNext;
  logic [1:0] ptr, ptrNext, ptrAfter, rrWinner, winner, grantNext;
  logic [3:0] cnt, cntNext, cntInc, reqMask, ackNext, doneNext;
  logic [7:0] holdNext;
  logic       errNext, prioHit, ptrAdv;
`ifdef XMIT_ARB_PRIO0_EN
  assign reqMask = {io.req[3:1], 1'b0};
  assign prioHit = io.req[0];
  assign ptrAdv  = io.grant_id != 2'd0;
`else
  assign reqMask = io.req;
  assign prioHit = 1'b0;
  assign ptrAdv  = 1'b1;
`endif
  assign winner   = prioHit ? 2'd0 : rrWinner;
  assign cntInc   = cnt + 4'd1;
  assign ptrAfter = ptrAdv ? io.grant_id + 2'd1 : ptr;
  // first requester at or after ptr, walking upward mod 4
  always_comb begin
    rrWinner = ptr;
    for (int i = 3; i >= 0; i--)
      if (reqMask[ptr + 2'(i)]) rrWinner = ptr + 2'(i);
  end
  // next-state and next registered-output decode
  always_comb begin
    stateNext = state;
    ptrNext   = ptr;
    grantNext = io.grant_id;
    holdNext  = io.xmit_data_o;
    cntNext   = cnt;
    ackNext   = '0;
    doneNext  = '0;
    errNext   = 1'b0;
    case (state)
      IDLE:
        if (|io.req && io.xmit_done_i) begin
          stateNext = ISSUE;
          grantNext = winner;
          holdNext  = io.req_data[{winner, 3'b000} +: 8];
          ackNext   = 4'b0001 << winner;
        end
      ISSUE: begin
        stateNext = WAIT_BUSY;
        cntNext   = '0;
      end
      WAIT_BUSY:
        if (!io.xmit_done_i) stateNext = WAIT_DONE;
        else begin
          cntNext = cntInc;
          if (cntInc == 4'(TMO_CYC)) begin
            errNext   = 1'b1;
            stateNext = IDLE;
            ptrNext   = ptrAfter;
          end
        end
      WAIT_DONE:
        if (io.xmit_done_i) begin
          doneNext  = 4'b0001 << io.grant_id;
          stateNext = IDLE;
          ptrNext   = ptrAfter;
        end
      default: stateNext = IDLE;
    endcase
  end
  // state, pointer, counter and all outputs; reset clears everything at once
  always_ff @(posedge sys_clk or negedge sys_rst_l)
    if (!sys_rst_l) begin
      state          <= IDLE;
      ptr            <= '0;
      cnt            <= '0;
      io.grant_id    <= '0;
      io.xmit_data_o <= '0;
      io.ack         <= '0;
      io.done        <= '0;
      io.err         <= 1'b0;
      io.busy        <= 1'b0;
      io.xmit_o      <= 1'b0;
    end else begin
      state          <= stateNext;
      ptr            <= ptrNext;
      cnt            <= cntNext;
      io.grant_id    <= grantNext;
      io.xmit_data_o <= holdNext;
      io.ack         <= ackNext;
      io.done        <= doneNext;
      io.err         <= errNext;
      io.busy        <= stateNext != IDLE;
      io.xmit_o      <= state == ISSUE;
    end
endmodule

// File: tb/tb_xmit_arb_ctrl.sv
// tb_xmit_arb_ctrl: scoreboard bench for xmit_arb_ctrl with a simple UART transmitter model
module tb_xmit_arb_ctrl;
  typedef struct packed {
    logic [3:0] ack;
    logic [1:0] gid;
    logic [7:0] data;
  } exp_t;
  logic sys_clk = 1'b0;
  logic sys_rst_l = 1'b1;
  logic txIdle = 1'b1;
  logic txStuck = 1'b0;
  logic txForceLow = 1'b0;
  int   txCnt = 0;
  int   txLen = 160;
  int   total = 0;
  int   passed = 0;
  exp_t sbq[$];
  xmit_arb_ctrl_if io();
  xmit_arb_ctrl #(.TMO_CYC(7)) dut (.sys_clk(sys_clk), .sys_rst_l(sys_rst_l), .io(io.slave));
  always #5 sys_clk = ~sys_clk;
  assign io.xmit_done_i = txIdle && !txForceLow;
  // transmitter: goes busy 2 cycles after the strobe, idle again txLen cycles after it
  always @(negedge sys_clk) begin
    if (!sys_rst_l) begin
      txCnt  <= 0;
      txIdle <= 1'b1;
    end else if (txCnt > 0) begin
      txCnt <= (txCnt == txLen) ? 0 : txCnt + 1;
      if (txCnt == 1) txIdle <= 1'b0;
      if (txCnt == txLen) txIdle <= 1'b1;
    end else if (io.xmit_o && !txStuck) txCnt <= 1;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end
  task automatic do_reset();
    io.req = '0;
    txForceLow = 1'b0;
    txStuck = 1'b0;
    sys_rst_l = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_l = 1'b1;
    @(negedge sys_clk);
  endtask
  task automatic test_reset();
    io.req = 4'b1111;
    io.req_data = 32'hFFFF_FFFF;
    #1 sys_rst_l = 1'b0;
    #1 total++;
    if ({io.ack, io.done, io.err, io.busy, io.grant_id, io.xmit_o, io.xmit_data_o} !== 21'd0)
      $display("FAIL reset_outputs: got %h want 0", {io.ack, io.done, io.err, io.busy, io.grant_id, io.xmit_o, io.xmit_data_o});
    else passed++;
    repeat (3) @(negedge sys_clk);
    total++;
    if ({io.ack, io.busy} !== 5'd0) $display("FAIL reset_held: got ack=%b busy=%b want 0", io.ack, io.busy);
    else passed++;
    io.req = '0;
    sys_rst_l = 1'b1;
    @(negedge sys_clk);
  endtask
  task automatic test_single();
    exp_t e;
    int n;
    logic early, unstable;
    do_reset();
    txLen = 160;
    io.req_data = 32'h11A5_2233;
    io.req = 4'b0100;
    sbq.push_back({4'b0100, 2'd2, 8'hA5});
    n = 0;
    while (io.ack === 4'b0 && n < 10) begin @(negedge sys_clk); n++; end
    e = sbq.pop_front();
    total++; if (io.ack !== e.ack) $display("FAIL single_ack: got %b want %b", io.ack, e.ack); else passed++;
    total++; if (io.grant_id !== e.gid) $display("FAIL single_grant: got %0d want %0d", io.grant_id, e.gid); else passed++;
    total++; if (io.busy !== 1'b1) $display("FAIL single_busy: got %b want 1", io.busy); else passed++;
    io.req = '0;
    @(negedge sys_clk);
    total++; if (io.xmit_o !== 1'b1) $display("FAIL single_xmit: got %b want 1", io.xmit_o); else passed++;
    total++; if (io.xmit_data_o !== e.data) $display("FAIL single_data: got %h want %h", io.xmit_data_o, e.data); else passed++;
    @(negedge sys_clk);
    total++; if (io.xmit_o !== 1'b0) $display("FAIL single_xmit_pulse: got %b want 0", io.xmit_o); else passed++;
    n = 0;
    while (txIdle === 1'b1 && n < 10) begin @(negedge sys_clk); n++; end
    early = 1'b0;
    unstable = 1'b0;
    n = 0;
    while (txIdle === 1'b0 && n < 300) begin
      @(negedge sys_clk);
      n++;
      if (txIdle === 1'b0 && (io.done !== 4'b0 || io.err !== 1'b0)) early = 1'b1;
      if (io.xmit_data_o !== e.data) unstable = 1'b1;
    end
    total++; if (io.done !== e.ack) $display("FAIL single_done: got %b want %b", io.done, e.ack); else passed++;
    total++; if ({early, io.err} !== 2'b00) $display("FAIL single_no_early: got early=%b err=%b want 0", early, io.err); else passed++;
    total++; if (unstable !== 1'b0) $display("FAIL single_data_stable: got unstable=%b want 0", unstable); else passed++;
    @(negedge sys_clk);
    total++; if ({io.done, io.busy} !== 5'd0) $display("FAIL single_after: got done=%b busy=%b want 0", io.done, io.busy); else passed++;
  endtask
  task automatic test_round_robin();
    exp_t e;
    int n, g;
    do_reset();
    txLen = 6;
    io.req_data = 32'h4030_2010;
    io.req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
`ifdef XMIT_ARB_PRIO0_EN
      g = 0;
`else
      g = i;
`endif
      sbq.push_back({4'b0001 << g, 2'(g), 8'(16 * (g + 1))});
    end
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (io.ack === 4'b0 && n < 40) begin @(negedge sys_clk); n++; end
      e = sbq.pop_front();
      total++; if (io.ack !== e.ack) $display("FAIL rr_ack[%0d]: got %b want %b", i, io.ack, e.ack); else passed++;
      total++; if (io.grant_id !== e.gid) $display("FAIL rr_grant[%0d]: got %0d want %0d", i, io.grant_id, e.gid); else passed++;
      @(negedge sys_clk);
      total++; if (io.xmit_data_o !== e.data) $display("FAIL rr_data[%0d]: got %h want %h", i, io.xmit_data_o, e.data); else passed++;
      n = 0;
      while (io.done === 4'b0 && n < 40) begin @(negedge sys_clk); n++; end
      total++; if (io.done !== e.ack) $display("FAIL rr_done[%0d]: got %b want %b", i, io.done, e.ack); else passed++;
    end
    io.req = '0;
  endtask
  task automatic test_timeout();
    exp_t e;
    int n;
    do_reset();
    txStuck = 1'b1;
    io.req_data = 32'h0000_5C00;
    io.req = 4'b0010;
    sbq.push_back({4'b0010, 2'd1, 8'h5C});
    n = 0;
    while (io.ack === 4'b0 && n < 10) begin @(negedge sys_clk); n++; end
    e = sbq.pop_front();
    total++; if (io.ack !== e.ack) $display("FAIL tmo_ack: got %b want %b", io.ack, e.ack); else passed++;
    io.req = '0;
    @(negedge sys_clk);
    total++; if (io.xmit_o !== 1'b1) $display("FAIL tmo_xmit: got %b want 1", io.xmit_o); else passed++;
    n = 0;
    while (io.err !== 1'b1 && n < 20) begin @(negedge sys_clk); n++; end
    total++; if (n !== 7) $display("FAIL tmo_cycles: got %0d want 7", n); else passed++;
    total++; if ({io.done, io.busy} !== 5'd0) $display("FAIL tmo_idle: got done=%b busy=%b want 0", io.done, io.busy); else passed++;
    @(negedge sys_clk);
    total++; if (io.err !== 1'b0) $display("FAIL tmo_err_pulse: got %b want 0", io.err); else passed++;
    txStuck = 1'b0;
    txLen = 6;
    io.req_data = 32'h00BB_AA00;
    io.req = 4'b0110;
    sbq.push_back({4'b0100, 2'd2, 8'hBB});
    n = 0;
    while (io.ack === 4'b0 && n < 10) begin @(negedge sys_clk); n++; end
    e = sbq.pop_front();
    total++; if (io.ack !== e.ack) $display("FAIL tmo_ptr_ack: got %b want %b", io.ack, e.ack); else passed++;
    total++; if (io.grant_id !== e.gid) $display("FAIL tmo_ptr_grant: got %0d want %0d", io.grant_id, e.gid); else passed++;
    io.req = '0;
  endtask
  task automatic test_reset_mid();
    exp_t e;
    int n;
    logic bad;
    do_reset();
    txLen = 8;
    io.req_data = 32'h00CC_00DD;
    io.req = 4'b0001;
    sbq.push_back({4'b0001, 2'd0, 8'hDD});
    n = 0;
    while (io.ack === 4'b0 && n < 10) begin @(negedge sys_clk); n++; end
    e = sbq.pop_front();
    total++; if (io.ack !== e.ack) $display("FAIL mid_first_ack: got %b want %b", io.ack, e.ack); else passed++;
    io.req = '0;
    n = 0;
    while (io.done === 4'b0 && n < 40) begin @(negedge sys_clk); n++; end
    total++; if (io.done !== e.ack) $display("FAIL mid_first_done: got %b want %b", io.done, e.ack); else passed++;
    io.req = 4'b0100;
    sbq.push_back({4'b0100, 2'd2, 8'hCC});
    n = 0;
    while (io.ack === 4'b0 && n < 10) begin @(negedge sys_clk); n++; end
    e = sbq.pop_front();
    total++; if (io.ack !== e.ack) $display("FAIL mid_second_ack: got %b want %b", io.ack, e.ack); else passed++;
    io.req = '0;
    n = 0;
    while (txIdle === 1'b1 && n < 10) begin @(negedge sys_clk); n++; end
    repeat (2) @(negedge sys_clk);
    total++; if (io.busy !== 1'b1) $display("FAIL mid_busy: got %b want 1", io.busy); else passed++;
    #2 sys_rst_l = 1'b0;
    #1 total++;
    if ({io.ack, io.done, io.err, io.busy, io.grant_id, io.xmit_o, io.xmit_data_o} !== 21'd0)
      $display("FAIL mid_async_clear: got %h want 0", {io.ack, io.done, io.err, io.busy, io.grant_id, io.xmit_o, io.xmit_data_o});
    else passed++;
    repeat (2) @(negedge sys_clk);
    sys_rst_l = 1'b1;
    bad = 1'b0;
    repeat (3) begin
      @(negedge sys_clk);
      if ({io.ack, io.done, io.err} !== 9'd0) bad = 1'b1;
    end
    total++; if (bad !== 1'b0) $display("FAIL mid_no_pulse: got bad=%b want 0", bad); else passed++;
    io.req = 4'b0011;
    sbq.push_back({4'b0001, 2'd0, 8'hDD});
    n = 0;
    while (io.ack === 4'b0 && n < 10) begin @(negedge sys_clk); n++; end
    e = sbq.pop_front();
    total++; if (io.ack !== e.ack) $display("FAIL mid_rearb_ack: got %b want %b", io.ack, e.ack); else passed++;
    total++; if (io.grant_id !== e.gid) $display("FAIL mid_rearb_grant: got %0d want %0d", io.grant_id, e.gid); else passed++;
    io.req = '0;
  endtask
  task automatic test_idle_busy();
    exp_t e;
    int n;
    logic quiet;
    do_reset();
    txLen = 6;
    txForceLow = 1'b1;
    io.req_data = 32'h0000_007E;
    io.req = 4'b0001;
    quiet = 1'b0;
    repeat (5) begin
      @(negedge sys_clk);
      if (io.ack !== 4'b0 || io.busy !== 1'b0) quiet = 1'b1;
    end
    total++; if (quiet !== 1'b0) $display("FAIL idle_hold_ack: got activity=%b want 0", quiet); else passed++;
    sbq.push_back({4'b0001, 2'd0, 8'h7E});
    txForceLow = 1'b0;
    n = 0;
    while (io.ack === 4'b0 && n < 5) begin @(negedge sys_clk); n++; end
    e = sbq.pop_front();
    total++; if (io.ack !== e.ack) $display("FAIL idle_release_ack: got %b want %b", io.ack, e.ack); else passed++;
    total++; if (io.grant_id !== e.gid) $display("FAIL idle_release_grant: got %0d want %0d", io.grant_id, e.gid); else passed++;
    io.req = '0;
    @(negedge sys_clk);
    total++; if (io.xmit_data_o !== e.data) $display("FAIL idle_release_data: got %h want %h", io.xmit_data_o, e.data); else passed++;
  endtask
  initial begin
    io.req = '0;
    io.req_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_idle_busy();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/xmit_arb_ctrl.md
XMIT_ARB_CTRL -- requirements
Module: xmit_arb_ctrl

Interface
REQ-001 Parameter: TMO_CYC, default 7, max cycles in WAIT_BUSY before abort (range 2..15, 4-bit counter).
REQ-002 sys_clk  in  1  clock; all logic rising-edge.
REQ-003 sys_rst_l  in  1  reset, asynchronous, active-low.
REQ-004 req  in  4  per-requester transmit request, level; bit i = requester i.
REQ-005 req_data  in  32  requester i byte on bits [8i+7:8i].
REQ-006 ack  out  4  one-cycle one-hot pulse: requester's byte latched.
REQ-007 done  out  4  one-cycle one-hot pulse: requester's byte fully transmitted.
REQ-008 err  out  1  one-cycle pulse: transmitter failed to start within TMO_CYC.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 grant_id  out  2  index of requester currently owning the transmitter.
REQ-011 xmit_o  out  1  start strobe to UART transmitter.
REQ-012 xmit_data_o  out  8  byte to UART transmitter.
REQ-013 xmit_done_i  in  1  transmitter idle/done flag; high while idle, low while sending.

Function
REQ-014 FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE; all outputs registered.
REQ-015 IDLE: when req!=0 AND xmit_done_i=1 at edge T, latch winner into grant_id, its byte into data hold register, assert ack[winner] during cycle T+1, go ISSUE.
REQ-016 IDLE with req=0 or xmit_done_i=0: stay IDLE, no ack.
REQ-017 ISSUE: xmit_o=1 for exactly this one cycle; go WAIT_BUSY; clear timeout counter.
REQ-018 xmit_data_o shall equal the hold register and stay stable from ISSUE until return to IDLE.
REQ-019 WAIT_BUSY: xmit_done_i=0 -> WAIT_DONE; else counter+1; counter reaching TMO_CYC -> err pulse next cycle, no done, go IDLE.
REQ-020 WAIT_DONE: xmit_done_i=1 -> done[grant_id] pulse next cycle, go IDLE; else stay.
REQ-021 Round-robin: search starts at ptr, ascending mod 4; ptr <= grant_id+1 (mod 4) on leaving WAIT_DONE or on timeout.
REQ-022 Requester holds req and data stable until ack; req still high in the cycle after ack counts as a new request.
REQ-023 req dropped before being sampled in IDLE: no ack, no transaction.
REQ-024 req changes while busy: ignored until IDLE; no queueing beyond the single hold register.
REQ-025 ack, done, err never asserted in the same cycle; at most one bit of ack/done set.
REQ-026 Minimum spacing: next ISSUE no earlier than 2 cycles after done pulse (IDLE re-samples xmit_done_i).

Reset
REQ-027 sys_rst_l low: state IDLE, ptr 0, grant_id 0, hold register 0, counter 0; ack, done, err, busy, xmit_o, xmit_data_o all 0, asynchronously.
REQ-028 Reset mid-transaction aborts it: no done or err pulse; first arbitration after release starts search at requester 0.

Configuration
REQ-029 Macro XMIT_ARB_PRIO0_EN defined: requester 0 wins whenever req[0]=1 in IDLE; requesters 1-3 round-robin among themselves; ptr unaffected by grants to 0.
REQ-030 Macro undefined: pure 4-way round-robin per REQ-021, requester 0 has no privilege.

Verification
REQ-031 Reset, req=4'b0100, data2=8'hA5, xmit_done_i held 1 -> ack=4'b0100 one cycle, xmit_o pulse next cycle, xmit_data_o=8'hA5.
REQ-032 Transmitter model drops xmit_done_i 2 cycles after xmit_o, high 160 cycles later -> done=4'b0100 one cycle after rise, busy low afterwards.
REQ-033 req=4'b1111 held continuously, 4 transactions -> grant order 0,1,2,3 (macro off); with XMIT_ARB_PRIO0_EN -> 0,0,0,0.
REQ-034 xmit_done_i stuck 1 after xmit_o, TMO_CYC=7 -> err pulse after 7 WAIT_BUSY cycles, no done, state IDLE, ptr advanced.
REQ-035 sys_rst_l pulsed low during WAIT_DONE -> all outputs 0 immediately, no done/err; next request of req=4'b0011 grants requester 0.
REQ-036 xmit_done_i=0 in IDLE with req=4'b0001 -> no ack until xmit_done_i returns 1.
